l1_tlb_array: RTL and testbench

- Parametrised, fully-associative L1 TLB. Holds tag, PPN and dirty state, performs a registered lookup, and refills itself from the page-table walker (PTW) on a miss.
- Supports ASID-selective and global flush.
- Sits between the core address-translation request path and the PTW.
- Adds over the earlier lookup-only logic: entry storage, replacement, a refill state machine and flush.

---
 rtl/l1_tlb_array.sv | 256 +++++++++++++++++++++++++
 tb/tb_l1_tlb_array.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_tlb_array.sv
`default_nettype none
// ============================================================================
// Module   : l1_tlb_array
// Brief    : Fully-associative L1 TLB. Registered lookup over {asid, vpn}
//            tags, refill from the page-table walker on a miss, round-robin
//            replacement when full, ASID-selective and global flush.
// Options  : define TLB_PERF_CNT_EN to add perf_hit_cnt / perf_miss_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module l1_tlb_array #(
    parameter int ENTRIES = 8,
    parameter int ASID_W  = 7,
    parameter int VPN_W   = 27,
    parameter int PPN_W   = 20
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              vm_enabled,
    input  logic [ASID_W-1:0] asid,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [VPN_W-1:0]  req_vpn,
    input  logic              req_store,
    input  logic              req_bad_va,
    output logic              resp_valid,
    output logic              resp_hit,
    output logic              resp_miss,
    output logic              resp_fault,
    output logic [PPN_W-1:0]  resp_ppn,
    output logic              ptw_req_valid,
    input  logic              ptw_req_ready,
    output logic [VPN_W-1:0]  ptw_req_vpn,
    input  logic              ptw_resp_valid,
    input  logic [PPN_W-1:0]  ptw_resp_ppn,
    input  logic              ptw_resp_dirty,
    input  logic              flush_valid,
    input  logic              flush_asid_only
`ifdef TLB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_hit_cnt,
    output logic [31:0]       perf_miss_cnt
`endif
);

    localparam int TAG_W = ASID_W + VPN_W;
    localparam int IDX_W = $clog2(ENTRIES);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PTW_REQ  = 2'd1,
        PTW_WAIT = 2'd2
    } state_t;

    state_t              r_state;
    logic [ENTRIES-1:0]  r_valid;
    logic [ENTRIES-1:0]  r_dirty;
    logic [TAG_W-1:0]    r_tag [ENTRIES];
    logic [PPN_W-1:0]    r_ppn [ENTRIES];
    logic [IDX_W-1:0]    r_rptr;
    logic [VPN_W-1:0]    r_vpn;
    logic [ASID_W-1:0]   r_asid;
    logic                r_flushed;   // a flush hit the walk in flight
    logic                r_resp_valid;
    logic                r_resp_hit;
    logic                r_resp_miss;
    logic                r_resp_fault;
    logic [PPN_W-1:0]    r_resp_ppn;

    logic [TAG_W-1:0]    w_req_tag;
    logic [TAG_W-1:0]    w_fill_tag;
    logic                w_hit;
    logic [IDX_W-1:0]    w_hit_idx;
    logic                w_dup;
    logic [IDX_W-1:0]    w_dup_idx;
    logic                w_free;
    logic [IDX_W-1:0]    w_free_idx;
    logic [IDX_W-1:0]    w_fill_idx;
    logic                w_fill;
    logic [ENTRIES-1:0]  w_fill_onehot;
    logic [ENTRIES-1:0]  w_flush_mask;
    logic                w_accept;
    logic [PPN_W-1:0]    w_pass_ppn;

    assign w_req_tag     = {asid, req_vpn};
    assign w_fill_tag    = {r_asid, r_vpn};
    assign req_ready     = (r_state == IDLE) && !flush_valid;
    assign w_accept      = req_valid && req_ready;
    assign ptw_req_valid = (r_state == PTW_REQ);
    assign ptw_req_vpn   = r_vpn;
    assign resp_valid    = r_resp_valid;
    assign resp_hit      = r_resp_hit;
    assign resp_miss     = r_resp_miss;
    assign resp_fault    = r_resp_fault;
    assign resp_ppn      = r_resp_ppn;

    // Untranslated mode maps VPN straight to PPN, truncated or zero-extended
    if (VPN_W >= PPN_W) begin : g_pass_trunc
        assign w_pass_ppn = req_vpn[PPN_W-1:0];
    end else begin : g_pass_zext
        assign w_pass_ppn = {{(PPN_W-VPN_W){1'b0}}, req_vpn};
    end

    // Lookup match; descending scan so the lowest matching index wins
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (r_valid[i] && (r_tag[i] == w_req_tag) && (!req_store || r_dirty[i])) begin
                w_hit     = 1'b1;
                w_hit_idx = IDX_W'(i);
            end
        end
    end

    // Refill victim: same-tag entry, else lowest free entry, else pointer
    always_comb begin
        w_dup      = 1'b0;
        w_dup_idx  = '0;
        w_free     = 1'b0;
        w_free_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (r_valid[i] && (r_tag[i] == w_fill_tag)) begin
                w_dup     = 1'b1;
                w_dup_idx = IDX_W'(i);
            end
            if (!r_valid[i]) begin
                w_free     = 1'b1;
                w_free_idx = IDX_W'(i);
            end
        end
        w_fill_idx = w_dup ? w_dup_idx : (w_free ? w_free_idx : r_rptr);
    end

    // Entries selected by the current flush request
    always_comb begin
        w_flush_mask = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            w_flush_mask[i] = flush_valid &&
                              (!flush_asid_only || (r_tag[i][TAG_W-1 -: ASID_W] == asid));
        end
    end

    // A flush seen during or coincident with the walk suppresses the write
    assign w_fill        = (r_state == PTW_WAIT) && ptw_resp_valid && !r_flushed && !flush_valid;
    assign w_fill_onehot = w_fill ? ({{(ENTRIES-1){1'b0}}, 1'b1} << w_fill_idx) : '0;

    // Request FSM, latched miss context and registered response
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_vpn        <= '0;
            r_asid       <= '0;
            r_flushed    <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_hit   <= 1'b0;
            r_resp_miss  <= 1'b0;
            r_resp_fault <= 1'b0;
            r_resp_ppn   <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_hit   <= 1'b0;
            r_resp_miss  <= 1'b0;
            r_resp_fault <= 1'b0;
            if (flush_valid && (r_state != IDLE)) begin
                r_flushed <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_flushed <= 1'b0;
                        if (!vm_enabled) begin
                            r_resp_valid <= 1'b1;
                            r_resp_hit   <= 1'b1;
                            r_resp_ppn   <= w_pass_ppn;
                        end else if (req_bad_va) begin
                            r_resp_valid <= 1'b1;
                            r_resp_fault <= 1'b1;
                            r_resp_ppn   <= '0;
                        end else if (w_hit) begin
                            r_resp_valid <= 1'b1;
                            r_resp_hit   <= 1'b1;
                            r_resp_ppn   <= r_ppn[w_hit_idx];
                        end else begin
                            r_vpn   <= req_vpn;
                            r_asid  <= asid;
                            r_state <= PTW_REQ;
                        end
                    end
                end
                PTW_REQ: begin
                    if (ptw_req_ready) begin
                        r_state <= PTW_WAIT;
                    end
                end
                PTW_WAIT: begin
                    if (ptw_resp_valid) begin
                        r_resp_valid <= 1'b1;
                        r_resp_hit   <= 1'b1;
                        r_resp_miss  <= 1'b1;
                        r_resp_ppn   <= ptw_resp_ppn;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Entry storage: refill write, flush invalidation, replacement pointer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= '0;
            r_dirty <= '0;
            r_rptr  <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_tag[i] <= '0;
                r_ppn[i] <= '0;
            end
        end else begin
            if (w_fill) begin
                r_tag[w_fill_idx]   <= w_fill_tag;
                r_ppn[w_fill_idx]   <= ptw_resp_ppn;
                r_dirty[w_fill_idx] <= ptw_resp_dirty;
                if (!w_dup && !w_free) begin
                    r_rptr <= r_rptr + IDX_W'(1);
                end
            end
            r_valid <= (r_valid & ~w_flush_mask) | w_fill_onehot;
        end
    end

`ifdef TLB_PERF_CNT_EN
    logic [31:0] r_perf_hit;
    logic [31:0] r_perf_miss;

    assign perf_hit_cnt  = r_perf_hit;
    assign perf_miss_cnt = r_perf_miss;

    // Count direct hits and PTW request handshakes, wrapping at 2^32
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_perf_hit  <= '0;
            r_perf_miss <= '0;
        end else begin
            if (r_resp_valid && r_resp_hit && !r_resp_miss) begin
                r_perf_hit <= r_perf_hit + 32'd1;
            end
            if (ptw_req_valid && ptw_req_ready) begin
                r_perf_miss <= r_perf_miss + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_l1_tlb_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_l1_tlb_array
// Brief    : Self-checking bench for l1_tlb_array against a behavioural TLB
//            model (tag/ppn/dirty table, free-slot and pointer replacement).
// Revision : 1.0 - initial release
// ============================================================================
module tb_l1_tlb_array;

    localparam int ENT = 8;

    typedef struct packed {
        logic        seen;
        logic        hit;
        logic        miss;
        logic        fault;
        logic [19:0] ppn;
        logic        walked;
        logic [26:0] wvpn;
        logic        timing_ok;
        logic        dup;
    } resp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        vm_enabled = 1'b0;
    logic [6:0]  asid = '0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [26:0] req_vpn = '0;
    logic        req_store = 1'b0;
    logic        req_bad_va = 1'b0;
    logic        resp_valid, resp_hit, resp_miss, resp_fault;
    logic [19:0] resp_ppn;
    logic        ptw_req_valid;
    logic        ptw_req_ready = 1'b0;
    logic [26:0] ptw_req_vpn;
    logic        ptw_resp_valid = 1'b0;
    logic [19:0] ptw_resp_ppn = '0;
    logic        ptw_resp_dirty = 1'b0;
    logic        flush_valid = 1'b0;
    logic        flush_asid_only = 1'b0;

    int asserts = 0;
    int failures = 0;

    // behavioural model
    bit          m_valid [ENT];
    logic [6:0]  m_asid  [ENT];
    logic [26:0] m_vpn   [ENT];
    logic [19:0] m_ppn   [ENT];
    bit          m_dirty [ENT];
    int          m_ptr;

    l1_tlb_array dut (
        .clk(clk), .reset_n(reset_n), .vm_enabled(vm_enabled), .asid(asid),
        .req_valid(req_valid), .req_ready(req_ready), .req_vpn(req_vpn),
        .req_store(req_store), .req_bad_va(req_bad_va),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_miss(resp_miss),
        .resp_fault(resp_fault), .resp_ppn(resp_ppn),
        .ptw_req_valid(ptw_req_valid), .ptw_req_ready(ptw_req_ready),
        .ptw_req_vpn(ptw_req_vpn), .ptw_resp_valid(ptw_resp_valid),
        .ptw_resp_ppn(ptw_resp_ppn), .ptw_resp_dirty(ptw_resp_dirty),
        .flush_valid(flush_valid), .flush_asid_only(flush_asid_only)
    );

    always #5 clk = ~clk;

    function automatic void m_reset();
        for (int i = 0; i < ENT; i++) m_valid[i] = 0;
        m_ptr = 0;
    endfunction

    function automatic int m_find(input logic [6:0] a, input logic [26:0] v, input logic st);
        for (int i = 0; i < ENT; i++)
            if (m_valid[i] && m_asid[i] == a && m_vpn[i] == v && (!st || m_dirty[i])) return i;
        return -1;
    endfunction

    function automatic void m_fill(input logic [6:0] a, input logic [26:0] v,
                                   input logic [19:0] p, input logic d);
        int idx = -1;
        for (int i = 0; i < ENT && idx < 0; i++)
            if (m_valid[i] && m_asid[i] == a && m_vpn[i] == v) idx = i;
        for (int i = 0; i < ENT && idx < 0; i++)
            if (!m_valid[i]) idx = i;
        if (idx < 0) begin
            idx = m_ptr;
            m_ptr = (m_ptr + 1) % ENT;
        end
        m_valid[idx] = 1; m_asid[idx] = a; m_vpn[idx] = v; m_ppn[idx] = p; m_dirty[idx] = d;
    endfunction

    function automatic void m_flush(input logic only, input logic [6:0] a);
        for (int i = 0; i < ENT; i++)
            if (!only || m_asid[i] == a) m_valid[i] = 0;
    endfunction

    // Drive one request and play the PTW; capture what the DUT answered
    task automatic issue(input logic vm, input logic [6:0] a, input logic [26:0] v,
                         input logic st, input logic bad, input logic [19:0] wppn,
                         input logic wd, input int hold, input int lat, input logic fl,
                         output resp_t g);
        int cyc, resp_cyc, phase, h, l;
        g = '0; resp_cyc = -10; phase = 0; h = hold; l = lat;
        @(negedge clk);
        vm_enabled = vm; asid = a; req_vpn = v; req_store = st; req_bad_va = bad; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 1;
        while (!g.seen && cyc <= 60) begin
            ptw_req_ready = 1'b0; ptw_resp_valid = 1'b0; flush_valid = 1'b0;
            if (resp_valid) begin
                g.seen = 1'b1; g.hit = resp_hit; g.miss = resp_miss;
                g.fault = resp_fault; g.ppn = resp_ppn;
                g.timing_ok = (phase == 0) ? (cyc == 1) : (cyc == resp_cyc + 1);
            end else if (phase == 0 && ptw_req_valid) begin
                g.walked = 1'b1; g.wvpn = ptw_req_vpn;
                if (h == 0) begin ptw_req_ready = 1'b1; phase = 1; end
                else h--;
            end else if (phase == 1) begin
                if (fl && l == lat) begin flush_valid = 1'b1; flush_asid_only = 1'b0; end
                if (l == 0) begin
                    ptw_resp_valid = 1'b1; ptw_resp_ppn = wppn; ptw_resp_dirty = wd;
                    resp_cyc = cyc; phase = 2;
                end else l--;
            end
            if (!g.seen) begin @(negedge clk); cyc++; end
        end
        ptw_req_ready = 1'b0; ptw_resp_valid = 1'b0; flush_valid = 1'b0;
        @(negedge clk);
        g.dup = resp_valid;
    endtask

    // Expected answer from the model, DUT transaction, then model update
    task automatic xact(input logic vm, input logic [6:0] a, input logic [26:0] v,
                        input logic st, input logic bad, input logic [19:0] wppn,
                        input logic wd, input int hold, input int lat, input logic fl,
                        output resp_t g, output resp_t e);
        int idx;
        e = '0; e.seen = 1'b1; e.timing_ok = 1'b1;
        idx = -1;
        if (!vm) begin e.hit = 1'b1; e.ppn = v[19:0]; end
        else if (bad) e.fault = 1'b1;
        else begin
            idx = m_find(a, v, st);
            if (idx >= 0) begin e.hit = 1'b1; e.ppn = m_ppn[idx]; end
            else begin e.hit = 1'b1; e.miss = 1'b1; e.ppn = wppn; e.walked = 1'b1; e.wvpn = v; end
        end
        issue(vm, a, v, st, bad, wppn, wd, hold, lat, fl, g);
        if (e.walked) begin
            if (fl) m_flush(1'b0, '0);
            else    m_fill(a, v, wppn, wd);
        end
    endtask

    task automatic do_flush(input logic only, input logic [6:0] a);
        @(negedge clk);
        flush_valid = 1'b1; flush_asid_only = only; asid = a;
        #1;
        asserts++;
        if (req_ready !== 1'b0) begin
            failures++; $display("FAIL flush_ready: req_ready=%b want 0", req_ready);
        end
        @(negedge clk);
        flush_valid = 1'b0;
        m_flush(only, a);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        m_reset();
        repeat (3) @(negedge clk);
        asserts++;
        if ({resp_valid, resp_hit, resp_miss, resp_fault, resp_ppn, ptw_req_valid, ptw_req_vpn} !== '0) begin
            failures++; $display("FAIL reset_outputs: got %h want 0",
                {resp_valid, resp_hit, resp_miss, resp_fault, resp_ppn, ptw_req_valid, ptw_req_vpn});
        end
        reset_n = 1'b1;
        @(negedge clk);
        asserts++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            failures++; $display("FAIL reset_ready: req_ready=%b resp_valid=%b want 1/0", req_ready, resp_valid);
        end
    endtask

    task automatic test_bypass();
        resp_t g, e;
        xact(1'b0, 7'd0, 27'h0012345, 1'b0, 1'b0, 20'h0, 1'b0, 0, 0, 1'b0, g, e);
        asserts++;
        if (g !== e || g.ppn !== 20'h12345 || g.walked !== 1'b0) begin
            failures++; $display("FAIL bypass: got %h want %h", g, e);
        end
    endtask

    task automatic test_miss_refill();
        resp_t g, e;
        xact(1'b1, 7'd3, 27'h100, 1'b0, 1'b0, 20'hABCDE, 1'b1, 1, 2, 1'b0, g, e);
        asserts++;
        if (g !== e || g.wvpn !== 27'h100 || g.miss !== 1'b1) begin
            failures++; $display("FAIL miss_refill: got %h want %h", g, e);
        end
        xact(1'b1, 7'd3, 27'h100, 1'b0, 1'b0, 20'h0, 1'b0, 0, 0, 1'b0, g, e);
        asserts++;
        if (g !== e || g.miss !== 1'b0 || g.ppn !== 20'hABCDE) begin
            failures++; $display("FAIL repeat_hit: got %h want %h", g, e);
        end
    endtask

    task automatic test_replacement();
        resp_t g, e;
        do_flush(1'b0, 7'd0);
        for (int k = 1; k <= 9; k++) begin
            xact(1'b1, 7'd0, 27'h1000 + 27'(k), 1'b0, 1'b0, 20'h50000 + 20'(k), 1'b1, 0, 1, 1'b0, g, e);
            asserts++;
            if (g !== e) begin
                failures++; $display("FAIL fill_%0d: got %h want %h", k, g, e);
            end
        end
        xact(1'b1, 7'd0, 27'h1002, 1'b0, 1'b0, 20'h0, 1'b0, 0, 0, 1'b0, g, e);
        asserts++;
        if (g !== e || g.miss !== 1'b0 || g.ppn !== 20'h50002) begin
            failures++; $display("FAIL vpn2_hit: got %h want %h", g, e);
        end
        xact(1'b1, 7'd0, 27'h1001, 1'b0, 1'b0, 20'h60001, 1'b1, 0, 0, 1'b0, g, e);
        asserts++;
        if (g !== e || g.miss !== 1'b1) begin
            failures++; $display("FAIL vpn1_evicted: got %h want %h", g, e);
        end
    endtask

    task automatic test_dirty();
        resp_t g, e;
        do_flush(1'b0, 7'd0);
        xact(1'b1, 7'd5, 27'h200, 1'b0, 1'b0, 20'h11111, 1'b0, 0, 1, 1'b0, g, e);
        asserts++;
        if (g !== e) begin failures++; $display("FAIL clean_fill: got %h want %h", g, e); end
        xact(1'b1, 7'd5, 27'h200, 1'b1, 1'b0, 20'h22222, 1'b1, 0, 1, 1'b0, g, e);
        asserts++;
        if (g !== e || g.miss !== 1'b1) begin failures++; $display("FAIL store_miss: got %h want %h", g, e); end
        xact(1'b1, 7'd5, 27'h200, 1'b0, 1'b0, 20'h0, 1'b0, 0, 0, 1'b0, g, e);
        asserts++;
        if (g !== e || g.ppn !== 20'h22222) begin failures++; $display("FAIL no_duplicate: got %h want %h", g, e); end
        xact(1'b1, 7'd5, 27'h200, 1'b1, 1'b0, 20'h0, 1'b0, 0, 0, 1'b0, g, e);
        asserts++;
        if (g !== e || g.miss !== 1'b0) begin failures++; $display("FAIL store_hit: got %h want %h", g, e); end
    endtask

    task automatic test_flush();
        resp_t g, e;
        do_flush(1'b0, 7'd0);
        xact(1'b1, 7'd1, 27'h300, 1'b0, 1'b0, 20'h0A001, 1'b1, 0, 0, 1'b0, g, e);
        xact(1'b1, 7'd2, 27'h300, 1'b0, 1'b0, 20'h0A002, 1'b1, 0, 0, 1'b0, g, e);
        do_flush(1'b1, 7'd1);
        xact(1'b1, 7'd2, 27'h300, 1'b0, 1'b0, 20'h0, 1'b0, 0, 0, 1'b0, g, e);
        asserts++;
        if (g !== e || g.miss !== 1'b0 || g.ppn !== 20'h0A002) begin
            failures++; $display("FAIL asid2_kept: got %h want %h", g, e);
        end
        xact(1'b1, 7'd1, 27'h300, 1'b0, 1'b0, 20'h0A101, 1'b1, 0, 0, 1'b0, g, e);
        asserts++;
        if (g !== e || g.miss !== 1'b1) begin failures++; $display("FAIL asid1_flushed: got %h want %h", g, e); end
        // flush during the wait, and flush coincident with the refill
        for (int lat = 0; lat < 3; lat += 2) begin
            xact(1'b1, 7'd1, 27'h400 + 27'(lat), 1'b0, 1'b0, 20'h0B000, 1'b1, 0, lat, 1'b1, g, e);
            asserts++;
            if (g !== e) begin failures++; $display("FAIL flush_walk_resp lat%0d: got %h want %h", lat, g, e); end
            xact(1'b1, 7'd1, 27'h400 + 27'(lat), 1'b0, 1'b0, 20'h0B111, 1'b1, 0, 0, 1'b0, g, e);
            asserts++;
            if (g !== e || g.miss !== 1'b1) begin
                failures++; $display("FAIL flush_walk_nofill lat%0d: got %h want %h", lat, g, e);
            end
        end
    endtask

    task automatic test_bad_va();
        resp_t g, e;
        xact(1'b1, 7'd3, 27'h100, 1'b0, 1'b1, 20'h0, 1'b0, 0, 0, 1'b0, g, e);
        asserts++;
        if (g !== e || g.fault !== 1'b1 || g.hit !== 1'b0 || g.walked !== 1'b0) begin
            failures++; $display("FAIL bad_va: got %h want %h", g, e);
        end
    endtask

    task automatic test_reset_mid_walk();
        resp_t g, e;
        @(negedge clk);
        vm_enabled = 1'b1; asid = 7'd4; req_vpn = 27'h777; req_store = 1'b0; req_bad_va = 1'b0; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 0; k < 20 && !ptw_req_valid; k++) @(negedge clk);
        asserts++;
        if (ptw_req_valid !== 1'b1) begin failures++; $display("FAIL midwalk_req: ptw_req_valid=%b want 1", ptw_req_valid); end
        ptw_req_ready = 1'b1;
        @(negedge clk);
        ptw_req_ready = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #2;
        asserts++;
        if (req_ready !== 1'b1 || ptw_req_valid !== 1'b0) begin
            failures++; $display("FAIL midwalk_async: req_ready=%b ptw_req_valid=%b want 1/0", req_ready, ptw_req_valid);
        end
        m_reset();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        ptw_resp_valid = 1'b1; ptw_resp_ppn = 20'hDEAD0; ptw_resp_dirty = 1'b1;
        @(negedge clk);
        ptw_resp_valid = 1'b0;
        asserts++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++; $display("FAIL late_ptw_resp: resp_valid=%b req_ready=%b want 0/1", resp_valid, req_ready);
        end
        xact(1'b1, 7'd4, 27'h777, 1'b0, 1'b0, 20'h0C777, 1'b0, 0, 0, 1'b0, g, e);
        asserts++;
        if (g !== e || g.miss !== 1'b1) begin failures++; $display("FAIL midwalk_empty: got %h want %h", g, e); end
    endtask

    task automatic test_random();
        resp_t g, e;
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 11) == 0) begin
                do_flush(1'($urandom_range(0, 1)), 7'($urandom_range(1, 2)));
            end else begin
                xact(1'($urandom_range(0, 9) != 0), 7'($urandom_range(1, 2)),
                     27'h2000 + 27'($urandom_range(0, 11)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 9) == 0), 20'($urandom), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 9) == 0), g, e);
                asserts++;
                if (g !== e) begin failures++; $display("FAIL random_%0d: got %h want %h", n, g, e); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_miss_refill();
        test_replacement();
        test_dirty();
        test_flush();
        test_bad_va();
        test_reset_mid_walk();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
`default_nettype wire
